// File: rtl/instruction_cache.sv
// Direct-mapped instruction cache with single-word refill handshake.
// Hits return data combinationally; misses stall while the line is fetched word by word.
module instruction_cache #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int LINES          = 16,
   parameter int WORDS_PER_LINE = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] pc_addr,
   input  logic              pc_valid,
   output logic [DATA_W-1:0] instruction_out,
   output logic              stall,
   input  logic              flush,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count
);

   localparam int WORD_W = $clog2(WORDS_PER_LINE);
   localparam int IDX_W  = $clog2(LINES);
   localparam int OFF_W  = 2 + WORD_W;
   localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
   localparam int LINE_W = ADDR_W - OFF_W;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      REFILL = 1'b1
   } state_t;

   state_t             state_r;
   state_t             state_next_s;
   logic [LINES-1:0]   valid_r;
   logic [TAG_W-1:0]   tag_r  [LINES];
   logic [DATA_W-1:0]  data_r [LINES][WORDS_PER_LINE];
   logic [LINE_W-1:0]  line_r;
   logic [WORD_W-1:0]  cnt_r;
   logic               abort_r;
   logic [31:0]        hit_r;
   logic [31:0]        miss_r;

   logic [TAG_W-1:0]   pc_tag_s;
   logic [IDX_W-1:0]   pc_idx_s;
   logic [WORD_W-1:0]  pc_word_s;
   logic [IDX_W-1:0]   refill_idx_s;
   logic [TAG_W-1:0]   refill_tag_s;
   logic               last_s;
   logic               hit_s;
   logic               miss_s;
   logic               unused_byte_bits_s;

   assign pc_tag_s           = pc_addr[ADDR_W-1:OFF_W+IDX_W];
   assign pc_idx_s           = pc_addr[OFF_W+IDX_W-1:OFF_W];
   assign pc_word_s          = pc_addr[OFF_W-1:2];
   assign refill_idx_s       = line_r[IDX_W-1:0];
   assign refill_tag_s       = line_r[LINE_W-1:IDX_W];
   assign last_s             = (cnt_r == WORD_W'(WORDS_PER_LINE - 1));
   assign unused_byte_bits_s = ^pc_addr[1:0];
   assign hit_count          = hit_r;
   assign miss_count         = miss_r;

   // State register; reset abandons any refill in flight.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Lookup, next-state and handshake outputs.
   always_comb begin
      state_next_s    = state_r;
      hit_s           = 1'b0;
      miss_s          = 1'b0;
      stall           = 1'b0;
      instruction_out = '0;
      mem_req         = 1'b0;
      mem_addr        = '0;
      case (state_r)
         IDLE: begin
            if (pc_valid) begin
               // A lookup coinciding with flush sees an already-invalidated cache.
               if (valid_r[pc_idx_s] && (tag_r[pc_idx_s] == pc_tag_s) && !flush) begin
                  hit_s           = 1'b1;
                  instruction_out = data_r[pc_idx_s][pc_word_s];
               end else begin
                  miss_s       = 1'b1;
                  stall        = 1'b1;
                  state_next_s = REFILL;
               end
            end else begin
               stall = 1'b0;
            end
         end
         REFILL: begin
            stall    = 1'b1;
            mem_req  = 1'b1;
            mem_addr = {line_r, cnt_r, 2'b00};
            if (mem_ack && last_s) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = REFILL;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // Valid bits, refill bookkeeping and performance counters.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valid_r <= '0;
         line_r  <= '0;
         cnt_r   <= '0;
         abort_r <= 1'b0;
         hit_r   <= 32'd0;
         miss_r  <= 32'd0;
      end else begin
         if (hit_s) begin
            hit_r <= hit_r + 32'd1;
         end
         if (miss_s) begin
            miss_r <= miss_r + 32'd1;
            line_r <= pc_addr[ADDR_W-1:OFF_W];
            cnt_r  <= '0;
         end
         if (flush) begin
            valid_r <= '0;
         end else if ((state_r == REFILL) && mem_ack && last_s && !abort_r) begin
            valid_r[refill_idx_s] <= 1'b1;
         end
         if (state_r == REFILL) begin
            if (mem_ack) begin
               cnt_r <= cnt_r + WORD_W'(1);
            end
            if (mem_ack && last_s) begin
               abort_r <= 1'b0;
            end else if (flush) begin
               abort_r <= 1'b1;
            end
         end
      end
   end

   // Data and tag storage; contents are qualified by valid_r so need no reset.
   always_ff @(posedge clock) begin
      if ((state_r == REFILL) && mem_ack) begin
         data_r[refill_idx_s][cnt_r] <= mem_rdata;
         if (last_s) begin
            tag_r[refill_idx_s] <= refill_tag_s;
         end
      end
   end

endmodule

// File: tb/tb_instruction_cache.sv
// Self-checking bench for instruction_cache: directed vector table, interrupted-refill
// sequences and randomized fetches against a line-level reference model.
module tb_instruction_cache;

   logic        clock;
   logic        reset;
   logic [31:0] pc_addr;
   logic        pc_valid;
   logic [31:0] instruction_out;
   logic        stall;
   logic        flush;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [31:0] hit_count;
   logic [31:0] miss_count;

   instruction_cache dut (
      .clock(clock), .reset(reset), .pc_addr(pc_addr), .pc_valid(pc_valid),
      .instruction_out(instruction_out), .stall(stall), .flush(flush),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct {
      logic [31:0] addr;
      int          period;
      bit          do_flush;
      bit          exp_hit;
   } vec_t;

   vec_t        vecs[10];
   int          total;
   int          bad;
   int          ack_period;
   int          ack_phase;
   bit          hold_pending;
   logic [31:0] hold_addr;
   logic [31:0] ack_log[$];
   logic [27:0] model_line[int];
   int          exp_hits;
   int          exp_misses;

   // Backing memory contents: 0x10..0x1C hold 0xA0..0xA3, every word distinct.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'hA0 + {2'b00, a[31:2]} - 32'd4;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit model_hit(input logic [31:0] a);
      int idx;
      idx = int'(a[7:4]);
      return model_line.exists(idx) && (model_line[idx] == a[31:4]);
   endfunction

   task automatic check_counters();
      chk("hit_count", hit_count, 32'(exp_hits));
      chk("miss_count", miss_count, 32'(exp_misses));
   endtask

   // One clock: memory responds to the current request, then advance past the edge.
   task automatic cycle();
      if (hold_pending && mem_req) chk("addr_stable", mem_addr, hold_addr);
      if (mem_req) begin
         ack_phase++;
         mem_ack   = ((ack_phase % ack_period) == 0);
         mem_rdata = mem_word(mem_addr);
         if (mem_ack) ack_log.push_back(mem_addr);
      end else begin
         ack_phase = 0;
         mem_ack   = 1'b0;
      end
      hold_pending = mem_req && !mem_ack;
      hold_addr    = mem_addr;
      @(posedge clock);
      #1;
      mem_ack = 1'b0;
   endtask

   task automatic fetch(input logic [31:0] a, input int period, input bit exp_hit, input bit do_flush);
      int          stalls;
      int          budget;
      logic [31:0] base;
      ack_period = period;
      ack_log.delete();
      base     = {a[31:4], 4'h0};
      pc_addr  = a;
      pc_valid = 1'b1;
      flush    = do_flush;
      #1;
      if (do_flush) model_line.delete();
      chk("lookup_stall", 32'(stall), 32'(!exp_hit));
      if (!stall) begin
         chk("hit_data", instruction_out, mem_word(a));
         exp_hits++;
         cycle();
      end else begin
         stalls = 0;
         budget = 200;
         while (stall && budget > 0) begin
            cycle();
            flush = 1'b0;
            stalls++;
            budget--;
         end
         if (budget == 0) chk("refill_timeout", 32'(stall), 32'd0);
         exp_misses++;
         chk("stall_cycles", 32'(stalls), 32'(1 + 4 * period));
         chk("ack_count", 32'(ack_log.size()), 32'd4);
         for (int k = 0; k < ack_log.size() && k < 4; k++)
            chk("refill_addr", ack_log[k], base + 32'(4 * k));
         chk("retry_data", instruction_out, mem_word(a));
         exp_hits++;
         cycle();
         model_line[int'(a[7:4])] = a[31:4];
      end
      pc_valid = 1'b0;
      flush    = 1'b0;
   endtask

   initial begin
      total = 0; bad = 0; exp_hits = 0; exp_misses = 0;
      ack_period = 1; ack_phase = 0; hold_pending = 1'b0; hold_addr = 32'd0;
      reset = 1'b0; pc_addr = 32'd0; pc_valid = 1'b0; flush = 1'b0;
      mem_ack = 1'b0; mem_rdata = 32'd0;

      vecs[0] = '{32'h0000_0010, 1, 1'b0, 1'b0};
      vecs[1] = '{32'h0000_001C, 1, 1'b0, 1'b1};
      vecs[2] = '{32'h0000_0110, 1, 1'b0, 1'b0};
      vecs[3] = '{32'h0000_0010, 1, 1'b0, 1'b0};
      vecs[4] = '{32'h0000_0014, 1, 1'b0, 1'b1};
      vecs[5] = '{32'h0000_0200, 3, 1'b0, 1'b0};
      vecs[6] = '{32'h0000_0208, 1, 1'b0, 1'b1};
      vecs[7] = '{32'h0000_0010, 1, 1'b1, 1'b0};
      vecs[8] = '{32'h0000_0013, 1, 1'b0, 1'b1};
      vecs[9] = '{32'h0000_0200, 2, 1'b0, 1'b0};

      // Reset state
      repeat (2) @(posedge clock);
      #1;
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_instr", instruction_out, 32'd0);
      check_counters();
      pc_valid = 1'b1;
      #1;
      chk("rst_pc_valid_stall", 32'(stall), 32'd1);
      pc_valid = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b1;
      #1;

      // Directed vector table
      for (int i = 0; i < 10; i++) begin
         fetch(vecs[i].addr, vecs[i].period, vecs[i].exp_hit, vecs[i].do_flush);
         check_counters();
         if (i == 0) chk("first_word", mem_word(32'h10), 32'h0000_00A0);
         if (i == 3) chk("conflict_misses", miss_count, 32'd3);
      end

      // Idle cycle: no output, no counter change
      pc_valid = 1'b0; pc_addr = 32'h0000_0010;
      #1;
      chk("idle_stall", 32'(stall), 32'd0);
      chk("idle_instr", instruction_out, 32'd0);
      cycle();
      check_counters();

      // Flush during the second refill word
      ack_period = 1; ack_log.delete();
      pc_addr = 32'h0000_0300; pc_valid = 1'b1;
      #1;
      cycle();
      cycle();
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      cycle();
      cycle();
      exp_misses++;
      model_line.delete();
      chk("abort_acks", 32'(ack_log.size()), 32'd4);
      chk("abort_refetch_stall", 32'(stall), 32'd1);
      chk("abort_mem_req", 32'(mem_req), 32'd0);
      fetch(32'h0000_0300, 1, 1'b0, 1'b0);
      check_counters();

      // Reset mid-refill
      ack_period = 1; ack_log.delete();
      pc_addr = 32'h0000_0400; pc_valid = 1'b1;
      #1;
      cycle();
      cycle();
      reset = 1'b0;
      #1;
      chk("midrst_mem_req", 32'(mem_req), 32'd0);
      chk("midrst_stall", 32'(stall), 32'd1);
      exp_hits = 0; exp_misses = 0;
      model_line.delete();
      check_counters();
      pc_valid = 1'b0;
      #1;
      cycle();
      reset = 1'b1;
      hold_pending = 1'b0;
      #1;
      fetch(32'h0000_0400, 1, 1'b0, 1'b0);
      check_counters();

      // Randomized fetches against the reference model
      for (int n = 0; n < 80; n++) begin
         logic [31:0] a;
         a = ($urandom_range(2, 0) << 8) | ($urandom_range(3, 0) << 4)
           | ($urandom_range(3, 0) << 2) | $urandom_range(3, 0);
         if ($urandom_range(3, 0) == 0) begin
            pc_valid = 1'b0; pc_addr = a;
            #1;
            chk("rnd_idle_stall", 32'(stall), 32'd0);
            chk("rnd_idle_instr", instruction_out, 32'd0);
            cycle();
         end else begin
            fetch(a, $urandom_range(3, 1), model_hit(a), ($urandom_range(15, 0) == 0));
         end
         check_counters();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instruction_cache.md
INSTRUCTION_CACHE -- requirements
Module: instruction_cache

Interface
REQ-001 Parameter ADDR_W, default 32: byte address width.
REQ-002 Parameter DATA_W, default 32: instruction word width.
REQ-003 Parameter LINES, default 16: number of direct-mapped lines, power of two, at least 2.
REQ-004 Parameter WORDS_PER_LINE, default 4: words per line, power of two, at least 2.
REQ-005 Port clock, input, 1: single clock; all state changes on the rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-low reset.
REQ-007 Port pc_addr, input, ADDR_W: fetch byte address; bits [1:0] ignored.
REQ-008 Port pc_valid, input, 1: fetch request this cycle.
REQ-009 Port instruction_out, output, DATA_W: fetched instruction.
REQ-010 Port stall, output, 1: instruction_out not valid; the pipeline holds the PC.
REQ-011 Port flush, input, 1: invalidate the whole cache.
REQ-012 Port mem_req, output, 1: refill word request to backing memory.
REQ-013 Port mem_addr, output, ADDR_W: word-aligned byte address of the requested word.
REQ-014 Port mem_ack, input, 1: backing memory returns mem_rdata this cycle.
REQ-015 Port mem_rdata, input, DATA_W: refill data.
REQ-016 Port hit_count and miss_count, outputs, 32 each: performance counters.

Function
REQ-017 Address split: offset = 2 + log2(WORDS_PER_LINE) low bits (byte bits, then word bits); index = next log2(LINES) bits; tag = remaining upper bits.
REQ-018 Storage: per line, a valid bit, a tag and WORDS_PER_LINE data words.
REQ-019 States: IDLE and REFILL only.
REQ-020 IDLE hit: pc_valid, valid[index] set and tag match -> combinational result in the same cycle: instruction_out = the addressed word, stall = 0.
REQ-021 IDLE miss: pc_valid without a hit -> stall = 1.
  - On the next edge, latch the line base address and move to REFILL.
  - Clear the word counter.
REQ-022 pc_valid = 0 -> stall = 0, instruction_out = 0, no counter change.
REQ-023 REFILL: stall = 1.
  - mem_req = 1 continuously.
  - mem_addr = latched base + 4 * counter.
REQ-024 Each edge with mem_ack = 1 in REFILL: write mem_rdata into the word at counter, then increment the counter.
REQ-025 Final ack (counter = WORDS_PER_LINE-1): write the tag, set valid unless an abort is pending, return to IDLE.
  - With ack every cycle, a miss stalls for 1 + WORDS_PER_LINE cycles.
  - The retried fetch hits on the following cycle.
REQ-026 mem_req stays high until mem_ack; mem_addr is stable while mem_req is high without ack.
REQ-027 pc_addr changes during REFILL are ignored; the latched line completes, then IDLE re-evaluates the current pc_addr.
REQ-028 flush in IDLE: all valid bits clear on the edge.
  - A lookup in the same cycle as flush is treated as a miss.
REQ-029 flush in REFILL: all valid bits clear and an abort flag sets.
  - The refill completes all handshakes, but the line stays invalid.
  - The abort flag clears on return to IDLE.
REQ-030 hit_count increments once per IDLE cycle that produces a hit.
REQ-031 miss_count increments once per IDLE-to-REFILL transition.
REQ-032 Both counters wrap from 0xFFFFFFFF to 0.

Reset
REQ-033 reset low, regardless of clock:
  - state = IDLE, mem_req = 0, mem_addr = 0.
  - All valid bits cleared, word counter = 0, abort flag = 0.
  - hit_count = 0, miss_count = 0.
  - stall = 0 unless pc_valid is high; instruction_out = 0 while pc_valid is low.
REQ-034 Reset during REFILL abandons the refill immediately.
  - mem_req deasserts asynchronously.
  - No partial line becomes valid.
REQ-035 Data and tag arrays need no reset.

Verification
REQ-036 Reset with pc_valid = 0 -> stall = 0, mem_req = 0, instruction_out = 0, both counters = 0.
REQ-037 Cold miss, pc_addr = 0x10, mem_ack every cycle, mem_rdata = 0xA0, 0xA1, 0xA2, 0xA3:
  - mem_addr = 0x10, 0x14, 0x18, 0x1C.
  - stall high for 5 cycles, then instruction_out = 0xA0.
  - miss_count = 1.
REQ-038 After REQ-037, pc_addr = 0x1C -> stall = 0 in the same cycle, instruction_out = 0xA3, hit_count increments by 1.
REQ-039 Conflict, defaults: fill 0x10, then fetch 0x110 (same index 1, different tag) -> miss and refill; then fetch 0x10 -> miss again; miss_count = 3.
REQ-040 Slow memory: mem_ack every third cycle -> mem_addr holds each value for 3 cycles; stall lasts 1 + 12 cycles.
REQ-041 Interrupted refills:
  - flush pulsed during the second refill word -> four handshakes complete, then the refetch of the same address misses.
  - reset pulsed mid-refill -> mem_req = 0 at once, and the next fetch misses.
